// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the SRAM-like responder: size codes, queue entry, LFSR.
package sram_like_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } entry_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order outstanding-request queue; every valid entry counts down, the head pops
// itself once its countdown is zero.
module sram_like_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  entry_t push_ent,
  output logic   head_ready,
  output entry_t head,
  output logic   full
);
  localparam int PW = $clog2(QDEPTH);

  entry_t            ent [QDEPTH];
  logic [QDEPTH-1:0] vld;
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic              pop;

  assign head       = ent[rptr];
  assign head_ready = vld[rptr] && (head.cnt == 4'd0);
  assign pop        = head_ready;
  assign full       = (count == (PW+1)'(QDEPTH));

  // push never targets a valid slot (caller gates on !full), so it cannot collide
  // with the countdown or the pop of the same entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (vld[i] && ent[i].cnt != 4'd0) ent[i].cnt <= ent[i].cnt - 4'd1;
      if (push) begin
        ent[wptr] <= push_ent;
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like req/addr_ok/data_ok memory responder with word storage and in-order queue.
// Define SRAM_LIKE_RESPONDER_RAND_DELAY_EN for LFSR-driven extra latency and addr_ok stalls.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] idx;
  logic          accept, full, head_ready, gate;
  logic [3:0]    init_cnt;
  entry_t        head, push_ent;

  assign idx = addr[AW+1:2];

`ifdef SRAM_LIKE_RESPONDER_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [4:0]  cnt_sum;
  logic        unused_lfsr;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_step(lfsr);

  // saturate: LATENCY up to 15 plus 3 extra would overflow the 4-bit countdown
  assign cnt_sum     = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
  assign init_cnt    = cnt_sum[4] ? 4'hF : cnt_sum[3:0];
  assign gate        = (lfsr[3:2] != 2'b11);
  assign unused_lfsr = ^lfsr[15:4];
`else
  assign init_cnt = 4'(LATENCY - 1);
  assign gate     = 1'b1;
`endif

  assign addr_ok  = resetn && !full && gate;
  assign accept   = req && addr_ok;
  assign push_ent = '{wr: wr, data: mem[idx], cnt: init_cnt};

  // byte lanes follow wstrb only; size is advisory for the initiator
  always_ff @(posedge clk)
    if (accept && wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];

  sram_like_resp_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_ent   (push_ent),
    .head_ready (head_ready),
    .head       (head),
    .full       (full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= head_ready;
      if (head_ready && !head.wr) rdata <= head.data;
    end
  end

  logic unused;
  assign unused = ^{size, addr[31:AW+2], addr[1:0], head.cnt};

endmodule
